fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_if.sv | 24 ++
 rtl/fetch_stage.sv | 103 ++++++++++
 tb/tb_fetch_stage.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory, redirect/stall and IF/ID signals of the fetch stage.
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_ir;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;

    modport master (
        output imem_req, imem_addr, id_valid, id_ir, id_pc, id_pc_plus4,
        input  imem_ready, imem_rdata, stall, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, id_valid, id_ir, id_pc, id_pc_plus4,
        output imem_ready, imem_rdata, stall, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC sequencing with a one-entry skid buffer (HOLD) and a drain state
// that swallows the response of a fetch overtaken by a redirect.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input logic           clk,
    input logic           rst,
    fetch_stage_if.master bus
);
    typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] hold_ir_q;
    logic [31:0] hold_pc_q;
    logic [31:0] pend_pc_q;
    logic        id_valid_q;
    logic [31:0] id_ir_q;
    logic [31:0] id_pc_q;
    logic [31:0] id_pc_plus4_q;
    logic [31:0] pc_plus4_d;
    logic [31:0] redirect_pc_d;

    assign pc_plus4_d    = pc_q + 32'd4;
    assign redirect_pc_d = {bus.redirect_pc[31:2], 2'b00};

    assign bus.imem_req    = !rst && state_q != HOLD;
    assign bus.imem_addr   = pc_q;
    assign bus.id_valid    = id_valid_q;
    assign bus.id_ir       = id_ir_q;
    assign bus.id_pc       = id_pc_q;
    assign bus.id_pc_plus4 = id_pc_plus4_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC;
            hold_ir_q     <= '0;
            hold_pc_q     <= '0;
            pend_pc_q     <= '0;
            id_valid_q    <= 1'b0;
            id_ir_q       <= NOP_INSTR;
            id_pc_q       <= '0;
            id_pc_plus4_q <= '0;
        end else begin
            // Redirect flushes IF/ID in every state and overrides stall.
            if (bus.redirect) begin
                id_valid_q <= 1'b0;
                id_ir_q    <= NOP_INSTR;
            end
            case (state_q)
                FETCH: begin
                    if (bus.redirect) begin
                        if (bus.imem_ready) begin
                            pc_q <= redirect_pc_d;
                        end else begin
                            pend_pc_q <= redirect_pc_d;
                            state_q   <= DRAIN;
                        end
                    end else if (bus.imem_ready) begin
                        pc_q <= pc_plus4_d;
                        if (bus.stall) begin
                            hold_ir_q <= bus.imem_rdata;
                            hold_pc_q <= pc_q;
                            state_q   <= HOLD;
                        end else begin
                            id_valid_q    <= 1'b1;
                            id_ir_q       <= bus.imem_rdata;
                            id_pc_q       <= pc_q;
                            id_pc_plus4_q <= pc_plus4_d;
                        end
                    end else if (!bus.stall) begin
                        id_valid_q <= 1'b0;
                        id_ir_q    <= NOP_INSTR;
                    end
                end
                HOLD: begin
                    if (bus.redirect) begin
                        pc_q    <= redirect_pc_d;
                        state_q <= FETCH;
                    end else if (!bus.stall) begin
                        id_valid_q    <= 1'b1;
                        id_ir_q       <= hold_ir_q;
                        id_pc_q       <= hold_pc_q;
                        id_pc_plus4_q <= hold_pc_q + 32'd4;
                        state_q       <= FETCH;
                    end
                end
                DRAIN: begin
                    // The stale response is dropped; the newest redirect target wins.
                    if (bus.imem_ready) begin
                        pc_q    <= bus.redirect ? redirect_pc_d : pend_pc_q;
                        state_q <= FETCH;
                    end else if (bus.redirect) begin
                        pend_pc_q <= redirect_pc_d;
                    end
                end
                default: state_q <= FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus random traffic, checked every cycle against a
// transaction-level model (next fetch PC, a queue of undelivered words, a poisoned-request flag).
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_stage_if bus ();
    fetch_stage dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [31:0] ir;
        logic [31:0] pc;
    } slot_t;

    int          checks = 0;
    int          failures = 0;
    slot_t       m_buf[$];
    logic [31:0] m_pc, m_tgt, m_ir, m_idpc, m_idp4;
    logic        m_poison, m_v;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a == 32'h0 ? 32'h0050_0093 :
               a == 32'h4 ? 32'h00A0_0113 :
               a == 32'h8 ? 32'h0020_81B3 : ({a[29:0], 2'b11} ^ 32'h5A5A_0000);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic compare();
        chk("imem_req", {31'b0, bus.imem_req}, {31'b0, !rst && m_buf.size() == 0});
        chk("imem_addr", bus.imem_addr, m_pc);
        chk("id_valid", {31'b0, bus.id_valid}, {31'b0, m_v});
        chk("id_ir", bus.id_ir, m_ir);
        chk("id_pc", bus.id_pc, m_idpc);
        chk("id_pc_plus4", bus.id_pc_plus4, m_idp4);
    endtask

    task automatic model_update();
        slot_t       s;
        logic        req;
        logic [31:0] t;
        req = m_buf.size() == 0;
        t   = bus.redirect_pc & 32'hFFFF_FFFC;
        if (rst) begin
            m_buf.delete();
            m_pc = 32'h0; m_tgt = 32'h0; m_poison = 1'b0;
            m_v = 1'b0; m_ir = NOP; m_idpc = 32'h0; m_idp4 = 32'h0;
        end else if (bus.redirect) begin
            m_v = 1'b0; m_ir = NOP;
            if (!req) begin
                m_buf.delete();
                m_pc = t;
            end else if (bus.imem_ready) begin
                m_pc = t;
                m_poison = 1'b0;
            end else begin
                m_poison = 1'b1;
                m_tgt = t;
            end
        end else begin
            if (req && bus.imem_ready) begin
                if (m_poison) begin
                    m_pc = m_tgt;
                    m_poison = 1'b0;
                end else begin
                    m_buf.push_back('{bus.imem_rdata, m_pc});
                    m_pc = m_pc + 32'd4;
                end
            end
            if (!bus.stall) begin
                if (m_buf.size() != 0) begin
                    s = m_buf.pop_front();
                    m_v = 1'b1; m_ir = s.ir; m_idpc = s.pc; m_idp4 = s.pc + 32'd4;
                end else begin
                    m_v = 1'b0; m_ir = NOP;
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic st, input logic rdy, input logic red,
                        input logic [31:0] rpc);
        @(negedge clk);
        rst = r;
        bus.stall = st;
        bus.imem_ready = rdy;
        bus.redirect = red;
        bus.redirect_pc = rpc;
        bus.imem_rdata = rdy ? mem(m_pc) : $urandom;
        #1 compare();
        @(posedge clk);
        #1 model_update();
    endtask

    initial begin
        rst = 1'b1;
        bus.stall = 1'b0; bus.imem_ready = 1'b1; bus.redirect = 1'b0;
        bus.redirect_pc = 32'h0; bus.imem_rdata = 32'h0;
        @(posedge clk);
        #1 model_update();
        chk("reset_valid", {31'b0, bus.id_valid}, 32'h0);
        chk("reset_ir", bus.id_ir, 32'h0000_0013);
        chk("reset_req", {31'b0, bus.imem_req}, 32'h0);
        chk("reset_addr", bus.imem_addr, 32'h0);
        // stream
        step(0, 0, 1, 0, 0);
        chk("s0_ir", bus.id_ir, 32'h0050_0093);
        chk("s0_p4", bus.id_pc_plus4, 32'h4);
        step(0, 0, 1, 0, 0);
        chk("s1_ir", bus.id_ir, 32'h00A0_0113);
        chk("s1_pc", bus.id_pc, 32'h4);
        step(0, 0, 1, 0, 0);
        chk("s2_ir", bus.id_ir, 32'h0020_81B3);
        chk("s2_pc", bus.id_pc, 32'h8);
        chk("s2_p4", bus.id_pc_plus4, 32'hC);
        // stall while the 0x4 word returns
        step(1, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        chk("hold_ir", bus.id_ir, 32'h0050_0093);
        chk("hold_req", {31'b0, bus.imem_req}, 32'h0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        chk("hold_req3", {31'b0, bus.imem_req}, 32'h0);
        step(0, 0, 1, 0, 0);
        chk("unhold_ir", bus.id_ir, 32'h00A0_0113);
        chk("unhold_pc", bus.id_pc, 32'h4);
        chk("unhold_addr", bus.imem_addr, 32'h8);
        // redirect with ready
        step(0, 0, 1, 1, 32'h103);
        chk("redir_valid", {31'b0, bus.id_valid}, 32'h0);
        chk("redir_addr", bus.imem_addr, 32'h100);
        // redirects while waiting
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'h200);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'h300);
        chk("drain_addr", bus.imem_addr, 32'h100);
        step(0, 0, 1, 0, 0);
        chk("drain_next", bus.imem_addr, 32'h300);
        chk("drain_valid", {31'b0, bus.id_valid}, 32'h0);
        // wrap
        step(0, 0, 1, 1, 32'hFFFF_FFFC);
        chk("wrap_addr0", bus.imem_addr, 32'hFFFF_FFFC);
        step(0, 0, 1, 0, 0);
        chk("wrap_pc", bus.id_pc, 32'hFFFF_FFFC);
        chk("wrap_p4", bus.id_pc_plus4, 32'h0);
        chk("wrap_addr", bus.imem_addr, 32'h0);
        // reset mid-HOLD
        step(0, 1, 1, 0, 0);
        chk("rh_req", {31'b0, bus.imem_req}, 32'h0);
        step(1, 1, 1, 0, 0);
        chk("rh_valid", {31'b0, bus.id_valid}, 32'h0);
        chk("rh_ir", bus.id_ir, 32'h0000_0013);
        chk("rh_addr", bus.imem_addr, 32'h0);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rpc;
            rpc = (($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + ($urandom_range(0, 3) * 4) : $urandom)
                  | $urandom_range(0, 3);
            step($urandom_range(0, 99) == 0, $urandom_range(0, 99) < 30,
                 $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 10, rpc);
        end
        step(0, 0, 1, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
